load_mem_stage: RTL and testbench

Memory-access stage of the load path. Consumes the 32-bit sign-extended immediate from the upstream sign extender plus the base register value, then forms the effective address. It then runs one word read over a req/ack memory handshake and produces a one-cycle register-file writeback for the destination register. It flags misaligned addresses and unresponsive memory instead of hanging.

---
 rtl/load_pkg.sv | 26 ++
 rtl/ea_calc.sv | 28 ++
 rtl/load_mem_stage.sv | 205 ++++++++++++++++++++
 tb/tb_load_mem_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// ---------------------------------------------------------------------------
// load_pkg
// Shared definitions for the load path: datapath widths, the alignment mask,
// the default memory timeout and the memory-stage state type.
// ---------------------------------------------------------------------------
package load_pkg;

   localparam int WORD_W          = 32;
   localparam int REG_IDX_W       = 5;
   localparam int CNT_W           = 8;   // wide enough for TIMEOUT up to 255
   localparam int DEFAULT_TIMEOUT = 15;

   localparam logic [1:0] ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      WAIT
   } state_t;

   // A word access is legal only when the low address bits are zero.
   function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
      return (addr[1:0] & ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/ea_calc.sv
// ---------------------------------------------------------------------------
// ea_calc
// Effective-address generator shared by the load and store stages.
// Purely combinational: ea = base + ext_imm (carry discarded, so the sum
// wraps modulo 2^32) and a flag for a non word-aligned result.
//
// Ports
//   base       in  32  base register value
//   ext_imm    in  32  sign-extended offset
//   ea         out 32  effective address
//   misaligned out  1  ea is not word aligned
// ---------------------------------------------------------------------------
module ea_calc
   import load_pkg::*;
(
   input  logic [WORD_W-1:0] base,
   input  logic [WORD_W-1:0] ext_imm,
   output logic [WORD_W-1:0] ea,
   output logic              misaligned
);

   logic [WORD_W-1:0] w_sum;

   assign w_sum      = base + ext_imm;
   assign ea         = w_sum;
   assign misaligned = is_misaligned(w_sum);

endmodule

// File: rtl/load_mem_stage.sv
// ---------------------------------------------------------------------------
// load_mem_stage
// Memory-access stage of the load path. Latches base, offset and destination
// register on start, forms the effective address, performs one word read
// over a req/ack handshake and issues a one-cycle register-file writeback.
// Misaligned addresses and a memory that never acks end the load with an
// error pulse instead of hanging. All outputs are registered.
//
// Parameters
//   TIMEOUT   consecutive no-ack WAIT cycles before abort (1..255)
//
// Ports
//   clk            in   1  rising-edge clock
//   rst            in   1  synchronous active-high reset
//   start          in   1  begin a load (ignored while busy)
//   base           in  32  base register value, sampled on start
//   ext_imm        in  32  sign-extended offset, sampled on start
//   rt             in   5  destination register, sampled on start
//   busy           out  1  stage is not idle
//   mem_req        out  1  read request, held until ack or abort
//   mem_addr       out 32  word address, stable while mem_req is high
//   mem_ack        in   1  read data valid this cycle
//   mem_rdata      in  32  read data
//   wb_en          out  1  register-file write strobe (never for r0)
//   wb_reg         out  5  writeback register index
//   wb_data        out 32  writeback data
//   done           out  1  load finished (success or error)
//   misaligned_err out  1  load aborted: address not word aligned
//   timeout_err    out  1  load aborted: no ack within TIMEOUT cycles
// ---------------------------------------------------------------------------
module load_mem_stage
   import load_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WORD_W-1:0]    base,
   input  logic [WORD_W-1:0]    ext_imm,
   input  logic [REG_IDX_W-1:0] rt,
   output logic                 busy,
   output logic                 mem_req,
   output logic [WORD_W-1:0]    mem_addr,
   input  logic                 mem_ack,
   input  logic [WORD_W-1:0]    mem_rdata,
   output logic                 wb_en,
   output logic [REG_IDX_W-1:0] wb_reg,
   output logic [WORD_W-1:0]    wb_data,
   output logic                 done,
   output logic                 misaligned_err,
   output logic                 timeout_err
);

   // The abort fires on the sample that would make the count reach TIMEOUT.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   // Registered state and outputs
   state_t               r_state;
   logic [WORD_W-1:0]    r_base;
   logic [WORD_W-1:0]    r_imm;
   logic [REG_IDX_W-1:0] r_rt;
   logic [CNT_W-1:0]     r_wait_cnt;
   logic                 r_mem_req;
   logic [WORD_W-1:0]    r_mem_addr;
   logic                 r_wb_en;
   logic [REG_IDX_W-1:0] r_wb_reg;
   logic [WORD_W-1:0]    r_wb_data;
   logic                 r_done;
   logic                 r_mis_err;
   logic                 r_tmo_err;

   // Next-state values
   state_t               w_state_next;
   logic                 w_latch;
   logic [CNT_W-1:0]     w_cnt_next;
   logic                 w_req_next;
   logic [WORD_W-1:0]    w_addr_next;
   logic                 w_wb_en_next;
   logic [REG_IDX_W-1:0] w_wb_reg_next;
   logic [WORD_W-1:0]    w_wb_data_next;
   logic                 w_done_next;
   logic                 w_mis_next;
   logic                 w_tmo_next;

   logic [WORD_W-1:0]    w_ea;
   logic                 w_misaligned;

   ea_calc u_ea_calc (
      .base       (r_base),
      .ext_imm    (r_imm),
      .ea         (w_ea),
      .misaligned (w_misaligned)
   );

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next   = r_state;
      w_latch        = 1'b0;
      w_cnt_next     = r_wait_cnt;
      w_req_next     = r_mem_req;
      w_addr_next    = r_mem_addr;
      w_wb_en_next   = 1'b0;
      w_wb_reg_next  = r_wb_reg;
      w_wb_data_next = r_wb_data;
      w_done_next    = 1'b0;
      w_mis_next     = 1'b0;
      w_tmo_next     = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               w_latch      = 1'b1;
               w_state_next = ADDR;
            end
         end

         ADDR: begin
            if (w_misaligned) begin
               // Abort before touching memory; mem_addr keeps its old value.
               w_done_next  = 1'b1;
               w_mis_next   = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_addr_next  = w_ea;
               w_req_next   = 1'b1;
               w_cnt_next   = '0;
               w_state_next = WAIT;
            end
         end

         WAIT: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (mem_ack) begin
               w_req_next     = 1'b0;
               w_wb_en_next   = (r_rt != '0);   // r0 is hard-wired zero
               w_wb_reg_next  = r_rt;
               w_wb_data_next = mem_rdata;
               w_done_next    = 1'b1;
               w_state_next   = IDLE;
            end else if (r_wait_cnt == LAST_WAIT) begin
               w_req_next   = 1'b0;
               w_done_next  = 1'b1;
               w_tmo_next   = 1'b1;
               w_state_next = IDLE;
            end else begin
               w_cnt_next = r_wait_cnt + 1'b1;
            end
         end

         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: registers are updated with non-blocking assignments so every
   // always_ff reads the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wait_cnt <= '0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_wb_en    <= 1'b0;
         r_wb_reg   <= '0;
         r_wb_data  <= '0;
         r_done     <= 1'b0;
         r_mis_err  <= 1'b0;
         r_tmo_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_cnt_next;
         r_mem_req  <= w_req_next;
         r_mem_addr <= w_addr_next;
         r_wb_en    <= w_wb_en_next;
         r_wb_reg   <= w_wb_reg_next;
         r_wb_data  <= w_wb_data_next;
         r_done     <= w_done_next;
         r_mis_err  <= w_mis_next;
         r_tmo_err  <= w_tmo_next;
      end
   end

   // NOTE: the operand latches carry no reset; they are always written on
   // start before anything reads them, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (w_latch) begin
         r_base <= base;
         r_imm  <= ext_imm;
         r_rt   <= rt;
      end
   end

   assign busy           = (r_state != IDLE);
   assign mem_req        = r_mem_req;
   assign mem_addr       = r_mem_addr;
   assign wb_en          = r_wb_en;
   assign wb_reg         = r_wb_reg;
   assign wb_data        = r_wb_data;
   assign done           = r_done;
   assign misaligned_err = r_mis_err;
   assign timeout_err    = r_tmo_err;

endmodule

// File: tb/tb_load_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_load_mem_stage
// Self-checking bench for load_mem_stage. A transaction-level model counts
// clock edges from the edge that accepts start and derives every output from
// those offsets; a negedge process compares the DUT to it each cycle.
// Directed loads pin the model with hand-computed literals, then randomized
// loads exercise alignment, wait lengths, timeouts and back-to-back starts.
// ---------------------------------------------------------------------------
module tb_load_mem_stage;
   import load_pkg::*;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base = '0;
   logic [31:0] ext_imm = '0;
   logic [4:0]  rt = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        busy, mem_req, wb_en, done, misaligned_err, timeout_err;
   logic [31:0] mem_addr, wb_data;
   logic [4:0]  wb_reg;

   load_mem_stage #(.TIMEOUT(T)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base           (base),
      .ext_imm        (ext_imm),
      .rt             (rt),
      .busy           (busy),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .wb_en          (wb_en),
      .wb_reg         (wb_reg),
      .wb_data        (wb_data),
      .done           (done),
      .misaligned_err (misaligned_err),
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit checks_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: one load in flight, timed by edge offset k from the
   // accepting edge. k=1: misaligned ends, or the request goes out.
   // k>=2: first edge with ack completes; no ack by k=1+T times out.
   // ------------------------------------------------------------------------
   int          ecnt = 0;
   int          m_e0 = 0;
   bit          m_act = 1'b0;
   logic [31:0] m_ea = '0;
   logic [4:0]  m_rt = '0;
   logic        exp_req = 1'b0, exp_done = 1'b0, exp_mis = 1'b0;
   logic        exp_tmo = 1'b0, exp_wb_en = 1'b0;
   logic [31:0] exp_addr = '0, exp_wb_data = '0;
   logic [4:0]  exp_wb_reg = '0;

   always @(posedge clk) begin
      ecnt      <= ecnt + 1;
      exp_done  <= 1'b0;
      exp_mis   <= 1'b0;
      exp_tmo   <= 1'b0;
      exp_wb_en <= 1'b0;
      if (rst) begin
         m_act       <= 1'b0;
         exp_req     <= 1'b0;
         exp_addr    <= '0;
         exp_wb_reg  <= '0;
         exp_wb_data <= '0;
      end else if (!m_act) begin
         if (start) begin
            m_act <= 1'b1;
            m_e0  <= ecnt;
            m_ea  <= base + ext_imm;
            m_rt  <= rt;
         end
      end else if (m_ea % 4 != 0) begin
         exp_done <= 1'b1;
         exp_mis  <= 1'b1;
         m_act    <= 1'b0;
      end else if (ecnt - m_e0 == 1) begin
         exp_addr <= m_ea;
         exp_req  <= 1'b1;
      end else if (mem_ack) begin
         exp_req     <= 1'b0;
         exp_done    <= 1'b1;
         exp_wb_en   <= (m_rt != 0);
         exp_wb_reg  <= m_rt;
         exp_wb_data <= mem_rdata;
         m_act       <= 1'b0;
      end else if (ecnt - m_e0 == 1 + T) begin
         exp_req  <= 1'b0;
         exp_done <= 1'b1;
         exp_tmo  <= 1'b1;
         m_act    <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (checks_on) begin
         check("busy",           busy,           m_act);
         check("mem_req",        mem_req,        exp_req);
         check("mem_addr",       mem_addr,       exp_addr);
         check("wb_en",          wb_en,          exp_wb_en);
         check("wb_reg",         wb_reg,         exp_wb_reg);
         check("wb_data",        wb_data,        exp_wb_data);
         check("done",           done,           exp_done);
         check("misaligned_err", misaligned_err, exp_mis);
         check("timeout_err",    timeout_err,    exp_tmo);
      end
   end

   // ------------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Runs one load. waits = no-ack WAIT samples before ack (-1: never ack).
   // lat = edge offset of done from the accepting edge; nreq = cycles with
   // mem_req high; freq = first offset with mem_req high (0 if none).
   task automatic load(input logic [31:0] b, input logic [31:0] imm, input logic [4:0] r,
                       input int waits, input logic [31:0] rd,
                       output int lat, output int nreq, output int freq);
      start   = 1'b1;
      base    = b;
      ext_imm = imm;
      rt      = r;
      step();
      lat  = 0;
      nreq = 0;
      freq = 0;
      for (int i = 1; i <= 40; i++) begin
         // Spurious start/operands while busy must be ignored.
         start     = ($urandom_range(0, 3) == 0);
         base      = $urandom;
         ext_imm   = $urandom;
         rt        = 5'($urandom);
         mem_ack   = (waits >= 0 && i == 2 + waits) || (i == 1 && $urandom_range(0, 1) == 1);
         mem_rdata = (i == 2 + waits) ? rd : $urandom;
         step();
         if (mem_req) begin
            nreq++;
            if (freq == 0) freq = i;
         end
         if (done) begin
            lat = i;
            break;
         end
      end
      start   = 1'b0;
      mem_ack = 1'b0;
      if (lat == 0) check("done_never_seen", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         mem_ack   = $urandom_range(0, 1);
         mem_rdata = $urandom;
         step();
      end
      mem_ack = 1'b0;
   endtask

   initial begin
      int lat, nreq, freq;
      logic [31:0] b, imm;
      int waits;

      rst = 1'b1;
      step();
      checks_on = 1'b1;
      check("rst_busy",     busy,     0);
      check("rst_mem_addr", mem_addr, 0);
      step();
      rst = 1'b0;
      idle(2);

      // Aligned zero-wait load
      load(32'h1000, 32'h10, 5'd8, 0, 32'hDEADBEEF, lat, nreq, freq);
      check("zw_latency",  lat,      2);
      check("zw_req_rise", freq,     1);
      check("zw_mem_addr", mem_addr, 32'h1010);
      check("zw_wb_en",    wb_en,    1);
      check("zw_wb_reg",   wb_reg,   8);
      check("zw_wb_data",  wb_data,  32'hDEADBEEF);
      idle(2);

      // Negative offset, 3 wait cycles (ack lands on the timeout sample)
      load(32'h1000, 32'hFFFFFFFC, 5'd3, 3, 32'h12345678, lat, nreq, freq);
      check("neg_latency",  lat,      5);
      check("neg_mem_addr", mem_addr, 32'h0FFC);
      check("neg_req_cyc",  nreq,     4);
      check("neg_tmo",      timeout_err, 0);
      check("neg_wb_data",  wb_data,  32'h12345678);
      idle(1);

      // Misaligned
      load(32'h1000, 32'h2, 5'd9, 0, 32'h0, lat, nreq, freq);
      check("mis_latency",  lat,            1);
      check("mis_err",      misaligned_err, 1);
      check("mis_req_cyc",  nreq,           0);
      check("mis_wb_en",    wb_en,          0);
      check("mis_mem_addr", mem_addr,       32'h0FFC);
      idle(1);

      // Timeout, ack never asserted
      load(32'h2000, 32'h4, 5'd10, -1, 32'h0, lat, nreq, freq);
      check("tmo_latency", lat,         1 + T);
      check("tmo_req_cyc", nreq,        T);
      check("tmo_err",     timeout_err, 1);
      check("tmo_wb_en",   wb_en,       0);
      check("tmo_wb_data", wb_data,     32'h12345678);
      step();
      check("tmo_busy_after", busy, 0);

      // rt=0, then back-to-back start during its done cycle
      load(32'h3000, 32'h8, 5'd0, 1, 32'hCAFEF00D, lat, nreq, freq);
      check("r0_done",    done,    1);
      check("r0_wb_en",   wb_en,   0);
      check("r0_wb_data", wb_data, 32'hCAFEF00D);
      load(32'h4000, 32'hFFFFFFFC, 5'd7, 0, 32'h0BADC0DE, lat, nreq, freq);
      check("b2b_req_rise", freq,     1);
      check("b2b_latency",  lat,      2);
      check("b2b_mem_addr", mem_addr, 32'h3FFC);
      check("b2b_wb_reg",   wb_reg,   7);

      // Address wrap-around
      load(32'hFFFFFFFC, 32'h8, 5'd5, 0, 32'h55AA55AA, lat, nreq, freq);
      check("wrap_mem_addr", mem_addr, 32'h4);
      idle(1);

      // Reset while waiting on memory
      start   = 1'b1;
      base    = 32'h5000;
      ext_imm = 32'h0;
      rt      = 5'd4;
      step();
      start = 1'b0;
      step();
      check("rw_req_before", mem_req, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rw_busy",     busy,     0);
      check("rw_mem_req",  mem_req,  0);
      check("rw_mem_addr", mem_addr, 0);
      check("rw_wb_reg",   wb_reg,   0);
      check("rw_wb_data",  wb_data,  0);
      check("rw_done",     done,     0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF0000;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rw_late_ack_done",  done,  0);
         check("rw_late_ack_wb_en", wb_en, 0);
      end
      mem_ack = 1'b0;

      // Randomized loads
      repeat (300) begin
         b   = $urandom;
         imm = $urandom;
         if ($urandom_range(0, 3) != 0) imm[1:0] = 2'(-b[1:0]);   // mostly aligned
         waits = int'($urandom_range(0, 6)) - 1;                  // -1..5
         load(b, imm, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), waits, $urandom,
              lat, nreq, freq);
         idle($urandom_range(0, 2));
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
